// File: rtl/data_break_responder.sv
// Data-break (DMA) responder: holds the PDP-8 at an instruction boundary
// and performs single-word reads/writes for the disk data mover, in bursts.
module data_break_responder #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        dmaREQ,
    input  logic        dmaRD,
    input  logic        dmaWR,
    input  logic [0:14] dmaADDR,
    input  logic [0:11] dmaDOUT,
    output logic [0:11] dmaDIN,
    output logic        dmaGNT,
    input  logic        break_ok,
    output logic        cpu_hold,
    output logic [0:14] mem_addr,
    output logic [0:11] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [0:11] mem_rdata,
    output logic        dma_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DATA,
        S_RELEASE,
        S_GAP
    } state_t;

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    state_t      state_q, state_d;
    logic [0:14] addr_q, addr_d;
    logic [0:11] wdata_q, wdata_d;
    logic [0:11] din_q, din_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        take;
    logic        is_wr;
    logic        is_rd;

    // A legal request has exactly one of read/write set.
    assign is_wr = wr_q & ~rd_q;
    assign is_rd = rd_q & ~wr_q;

    // State and latched request registers; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: wait for a break point, then run words back to back.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (dmaREQ) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!dmaREQ) begin
                    state_d = S_IDLE;
                end else if (break_ok) begin
                    take    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!is_wr && !is_rd) err_d = 1'b1;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (is_rd) din_d = mem_rdata;
                cnt_d   = cnt_q + 4'd1;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!dmaREQ) begin
                    state_d = S_IDLE;
                end else if (cnt_q < MAXB) begin
                    take    = 1'b1;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture the requester's word when a new access is started.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (take) begin
            addr_d  = dmaADDR;
            wdata_d = dmaDOUT;
            rd_d    = dmaRD;
            wr_d    = dmaWR;
        end
    end

    assign cpu_hold  = (state_q == S_WAIT) || (state_q == S_ACCESS) ||
                       (state_q == S_DATA) || (state_q == S_RELEASE);
    assign mem_we    = (state_q == S_ACCESS) && is_wr;
    assign mem_re    = (state_q == S_ACCESS) && is_rd;
    assign dmaGNT    = (state_q == S_DATA);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dmaDIN    = din_q;
    assign dma_err   = err_q;

endmodule

// File: tb/tb_data_break_responder.sv
// Bench for data_break_responder: directed test-plan cases with literal
// expectations, then random traffic checked against a transfer-level model.
module tb_data_break_responder;

    localparam int MAXB = 4;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        dmaREQ;
    logic        dmaRD;
    logic        dmaWR;
    logic [0:14] dmaADDR;
    logic [0:11] dmaDOUT;
    logic [0:11] dmaDIN;
    logic        dmaGNT;
    logic        break_ok;
    logic        cpu_hold;
    logic [0:14] mem_addr;
    logic [0:11] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [0:11] mem_rdata;
    logic        dma_err;

    data_break_responder #(.MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .dmaREQ(dmaREQ), .dmaRD(dmaRD), .dmaWR(dmaWR),
        .dmaADDR(dmaADDR), .dmaDOUT(dmaDOUT), .dmaDIN(dmaDIN),
        .dmaGNT(dmaGNT), .break_ok(break_ok), .cpu_hold(cpu_hold),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .dma_err(dma_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    function automatic logic [11:0] init_word(int a);
        return 12'((a * 37 + 5) ^ (a >> 3));
    endfunction

    // Bench memory: written by the DUT, read data returned one cycle later.
    logic [11:0] bmem [0:32767];
    bit          bwr  [0:32767];

    function automatic logic [11:0] brd(int a);
        return bwr[a] ? bmem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            bmem[int'(mem_addr)] <= mem_wdata;
            bwr[int'(mem_addr)]  <= 1'b1;
        end
        if (mem_re) mem_rdata <= brd(int'(mem_addr));
    end

    // Transfer-level model: m_age counts cycles since a word was accepted
    // (1 strobe, 2 grant, 3 requester's turn); 0 means no word in flight.
    logic [11:0] mmem [0:32767];
    bit          mwr  [0:32767];
    bit          m_hold, m_gap, m_err, m_rd, m_wr;
    int          m_age, m_words;
    logic [0:14] m_addr;
    logic [0:11] m_wdata, m_din;

    function automatic logic [11:0] mrd(int a);
        return mwr[a] ? mmem[a] : init_word(a);
    endfunction

    function automatic bit m_lw();
        return m_wr && !m_rd;
    endfunction

    function automatic bit m_lr();
        return m_rd && !m_wr;
    endfunction

    task automatic m_accept();
        m_addr  = dmaADDR;
        m_wdata = dmaDOUT;
        m_rd    = dmaRD;
        m_wr    = dmaWR;
        m_age   = 1;
    endtask

    task automatic model_step();
        if (m_age == 1 && m_lw()) begin
            mmem[int'(m_addr)] = m_wdata;
            mwr[int'(m_addr)]  = 1'b1;
        end
        if (reset || clear) begin
            m_hold = 0; m_gap = 0; m_err = 0; m_rd = 0; m_wr = 0;
            m_age = 0; m_words = 0;
            m_addr = '0; m_wdata = '0; m_din = '0;
        end else if (m_age == 1) begin
            if (!m_lw() && !m_lr()) m_err = 1;
            m_age = 2;
        end else if (m_age == 2) begin
            if (m_lr()) m_din = mrd(int'(m_addr));
            m_words++;
            m_age = 3;
        end else if (m_age == 3) begin
            if (dmaREQ && m_words < MAXB) begin
                m_accept();
            end else begin
                m_age  = 0;
                m_hold = 0;
                m_gap  = dmaREQ;
            end
        end else if (m_gap) begin
            m_gap  = 0;
            m_hold = 1;
        end else if (m_hold) begin
            if (!dmaREQ) begin
                m_hold = 0;
            end else if (break_ok) begin
                m_words = 0;
                m_accept();
            end
        end else if (dmaREQ) begin
            m_hold = 1;
        end
    endtask

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o want %0o at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("hold", 32'(cpu_hold), 32'(m_hold));
            cmp("gnt", 32'(dmaGNT), 32'(m_age == 2));
            cmp("we", 32'(mem_we), 32'(m_age == 1 && m_lw()));
            cmp("re", 32'(mem_re), 32'(m_age == 1 && m_lr()));
            cmp("din", 32'(dmaDIN), 32'(m_din));
            cmp("err", 32'(dma_err), 32'(m_err));
            if (m_age == 1 && (m_lw() || m_lr()))
                cmp("addr", 32'(mem_addr), 32'(m_addr));
            if (m_age == 1 && m_lw())
                cmp("wdata", 32'(mem_wdata), 32'(m_wdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(bit r, bit w, logic [0:14] a, logic [0:11] d);
        dmaREQ  = 1'b1;
        dmaRD   = r;
        dmaWR   = w;
        dmaADDR = a;
        dmaDOUT = d;
    endtask

    task automatic xfer(bit r, bit w, logic [0:14] a, logic [0:11] d);
        tick();
        set_req(r, w, a, d);
        break_ok = 1'b1;
        repeat (4) tick();
        dmaREQ = 1'b0;
        tick();
    endtask

    task automatic rand_req();
        int op;
        logic [0:14] a;
        op = $urandom_range(0, 9);
        a  = 15'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) a[0:2] = 3'b111;
        if (op <= 4)      set_req(1, 0, a, 12'($urandom));
        else if (op <= 8) set_req(0, 1, a, 12'($urandom));
        else begin
            op = $urandom_range(0, 1);
            set_req(op[0], op[0], a, 12'($urandom));
        end
    endtask

    int          gq[$];
    int          lows;
    bit          upd;
    logic [0:14] nxt;
    int          exp_g[6] = '{3, 6, 9, 12, 17, 20};

    initial begin
        reset = 1; clear = 0; dmaREQ = 0; dmaRD = 0; dmaWR = 0;
        dmaADDR = '0; dmaDOUT = '0; break_ok = 0;
        tick();
        tick();
        chk_en = 1;
        cmp("rst_hold", 32'(cpu_hold), 0);
        cmp("rst_gnt", 32'(dmaGNT), 0);
        cmp("rst_we", 32'(mem_we), 0);
        cmp("rst_re", 32'(mem_re), 0);
        cmp("rst_din", 32'(dmaDIN), 0);
        cmp("rst_addr", 32'(mem_addr), 0);
        cmp("rst_wdata", 32'(mem_wdata), 0);
        cmp("rst_err", 32'(dma_err), 0);
        reset = 0;

        // Single write
        tick();
        set_req(0, 1, 15'o12345, 12'o7070);
        break_ok = 1;
        tick();
        cmp("w_c1_hold", 32'(cpu_hold), 1);
        cmp("w_c1_we", 32'(mem_we), 0);
        tick();
        cmp("w_c2_we", 32'(mem_we), 1);
        cmp("w_c2_addr", 32'(mem_addr), 32'o12345);
        cmp("w_c2_data", 32'(mem_wdata), 32'o7070);
        tick();
        cmp("w_c3_gnt", 32'(dmaGNT), 1);
        cmp("w_c3_we", 32'(mem_we), 0);
        tick();
        dmaREQ = 0;
        cmp("w_c4_hold", 32'(cpu_hold), 1);
        cmp("w_c4_gnt", 32'(dmaGNT), 0);
        tick();
        cmp("w_c5_hold", 32'(cpu_hold), 0);
        cmp("w_mem", 32'(bmem[int'(15'o12345)]), 32'o7070);

        // Single read of a word placed by a prior write
        xfer(0, 1, 15'o00200, 12'o4321);
        tick();
        set_req(1, 0, 15'o00200, 12'o0);
        tick();
        tick();
        cmp("r_c2_re", 32'(mem_re), 1);
        cmp("r_c2_we", 32'(mem_we), 0);
        tick();
        cmp("r_c3_gnt", 32'(dmaGNT), 1);
        tick();
        dmaREQ = 0;
        cmp("r_c4_din", 32'(dmaDIN), 32'o4321);
        tick();
        tick();
        cmp("r_c6_din", 32'(dmaDIN), 32'o4321);

        // CPU not at a break point for 10 cycles
        tick();
        set_req(1, 0, 15'o00201, 12'o0);
        break_ok = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            cmp("hw_hold", 32'(cpu_hold), 1);
            cmp("hw_strobe", 32'(mem_we | mem_re), 0);
        end
        break_ok = 1;
        tick();
        cmp("hw_re", 32'(mem_re), 1);
        tick();
        cmp("hw_gnt", 32'(dmaGNT), 1);
        tick();
        dmaREQ = 0;
        cmp("hw_din", 32'(dmaDIN), 32'(init_word(int'(15'o00201))));
        tick();

        // Burst of six reads with a forced release after four
        tick();
        set_req(1, 0, 15'o00100, 12'o0);
        break_ok = 1;
        nxt = 15'o00101;
        upd = 0;
        lows = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (upd) begin
                if (nxt <= 15'o00105) begin
                    dmaADDR = nxt;
                    nxt = nxt + 15'd1;
                end else begin
                    dmaREQ = 0;
                end
                upd = 0;
            end
            if (dmaGNT) begin
                gq.push_back(c);
                upd = 1;
            end
            if (!cpu_hold && dmaREQ) lows++;
        end
        cmp("b_ngnt", 32'(gq.size()), 6);
        for (int i = 0; i < 6; i++)
            cmp("b_gnt_cycle", (i < gq.size()) ? 32'(gq[i]) : 32'hffff, 32'(exp_g[i]));
        cmp("b_gap", 32'(lows), 1);
        cmp("b_din", 32'(dmaDIN), 32'(init_word(int'(15'o00105))));

        // Illegal request: both read and write
        tick();
        set_req(1, 1, 15'o00300, 12'o0);
        tick();
        tick();
        cmp("il_we", 32'(mem_we), 0);
        cmp("il_re", 32'(mem_re), 0);
        tick();
        cmp("il_gnt", 32'(dmaGNT), 1);
        cmp("il_err", 32'(dma_err), 1);
        tick();
        dmaREQ = 0;
        tick();
        cmp("il_err_sticky", 32'(dma_err), 1);
        cmp("il_din", 32'(dmaDIN), 32'(init_word(int'(15'o00105))));
        tick();
        cmp("il_hold", 32'(cpu_hold), 0);
        cmp("il_err_sticky2", 32'(dma_err), 1);

        // Clear during the strobe cycle of a write
        tick();
        set_req(0, 1, 15'o00400, 12'o1111);
        tick();
        tick();
        cmp("cl_we", 32'(mem_we), 1);
        clear = 1;
        tick();
        clear = 0;
        dmaREQ = 0;
        cmp("cl_gnt", 32'(dmaGNT), 0);
        cmp("cl_hold", 32'(cpu_hold), 0);
        cmp("cl_we0", 32'(mem_we), 0);
        cmp("cl_addr", 32'(mem_addr), 0);
        cmp("cl_wdata", 32'(mem_wdata), 0);
        cmp("cl_din", 32'(dmaDIN), 0);
        cmp("cl_err", 32'(dma_err), 0);
        cmp("cl_mem", 32'(bmem[int'(15'o00400)]), 32'o1111);
        tick();
        cmp("cl_idle", 32'(cpu_hold), 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (m_age == 3) begin
                if ($urandom_range(0, 2) != 0) rand_req();
                else dmaREQ = 0;
            end else if (!dmaREQ) begin
                if ($urandom_range(0, 3) == 0) rand_req();
            end else if (m_hold && m_age == 0 && !m_gap &&
                         $urandom_range(0, 40) == 0) begin
                dmaREQ = 0;
            end
            break_ok = ($urandom_range(0, 9) < 7);
            clear = ($urandom_range(0, 60) == 0);
        end
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_break_responder.md
# data_break_responder

CPU-side responder for the data-break (DMA) interface driven by the RK8-E disk controller's SD data mover. It holds off the PDP-8 processor at a safe point and performs the requested single-word memory read or write on the 15-bit extended address. It returns a one-cycle grant, with read data on reads. Back-to-back requests are serviced as a bounded burst before the CPU is released.

## Interface
Parameters:
- MAX_BURST, default 4: maximum words serviced per CPU hold before a forced release (range 1..15).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- clear  input  1  IOCLR/CAF; synchronous, same effect as reset on this block
- dmaREQ  input  1  requester wants a data break; held until granted
- dmaRD  input  1  request is a memory read (memory -> device)
- dmaWR  input  1  request is a memory write (device -> memory)
- dmaADDR  input  [0:14]  field + address of the word
- dmaDOUT  input  [0:11]  write data from device
- dmaDIN  output  [0:11]  read data to device
- dmaGNT  output  1  one-cycle grant pulse; transfer complete
- break_ok  input  1  CPU is at an instruction boundary and may be held
- cpu_hold  output  1  freezes CPU major-state sequencing
- mem_addr  output  [0:14]  memory address
- mem_wdata  output  [0:11]  memory write data
- mem_we  output  1  memory write strobe
- mem_re  output  1  memory read strobe; mem_rdata valid the following cycle
- mem_rdata  input  [0:11]  memory read data
- dma_err  output  1  sticky protocol error

## Operation
- States: IDLE, WAIT, ACCESS, DATA, RELEASE, GAP.
- IDLE: cpu_hold=0. If dmaREQ=1 -> WAIT.
- WAIT: cpu_hold=1. When break_ok=1, latch dmaADDR, dmaDOUT, dmaRD and dmaWR, clear burst count -> ACCESS.
- ACCESS: mem_addr=latched address.
  - Write: mem_we=1 and mem_wdata=latched data.
  - Read: mem_re=1.
  - Illegal request (dmaRD=dmaWR, either both 1 or both 0): no strobe, dma_err<=1.
  - Next state -> DATA.
- DATA: dmaGNT=1. On a read, dmaDIN<=mem_rdata. Burst count increments -> RELEASE.
- RELEASE: dmaREQ is ignored for this one cycle while the requester drops or updates its request. Next cycle:
  - dmaREQ=1 and count<MAX_BURST: latch the new request -> ACCESS. cpu_hold stays 1.
  - dmaREQ=1 and count=MAX_BURST: -> GAP.
  - dmaREQ=0: -> IDLE.
- GAP: cpu_hold=0 for exactly one cycle -> WAIT. This guarantees the CPU progresses.
- cpu_hold=1 in WAIT, ACCESS, DATA and RELEASE; 0 in IDLE and GAP.
- mem_we, mem_re and dmaGNT are decoded from the registered state (Moore). They are never asserted outside ACCESS/DATA.
- dmaDIN holds its value until the next read grant. Writes and illegal requests leave it unchanged.
- dma_err is cleared only by reset or clear.
- Requester contract: dmaREQ, dmaRD, dmaWR, dmaADDR and dmaDOUT are stable from REQ rise through the grant cycle.

## Timing
- Reset/clear values: state=IDLE, cpu_hold=0, dmaGNT=0, mem_we=0, mem_re=0, dmaDIN=0, mem_addr=0, mem_wdata=0, dma_err=0, burst count=0.
- Minimum latency, with REQ rising in cycle 0 and break_ok=1: WAIT in 1, ACCESS in 2, dmaGNT in 3.
- Burst words 2..N: request latched in RELEASE, strobe 1 cycle later, grant 2 cycles later. That is a 3-cycle period per word.
- Read path: mem_re in ACCESS; mem_rdata sampled at the end of DATA; dmaDIN valid from the cycle after the grant. The requester captures dmaDIN on the cycle following dmaGNT.
- break_ok low while in WAIT: remain in WAIT indefinitely with cpu_hold=1.
- break_ok is ignored outside WAIT.
- dmaREQ dropping while in WAIT (protocol violation): return to IDLE with no access and no grant.
- reset/clear in ACCESS: any write strobed in that cycle completes at the edge. The next state is IDLE and no grant is issued.
- reset/clear in DATA: the grant in that cycle still appears, because outputs are decoded from state. The next state is IDLE.
- reset/clear wins over every other transition.

## Test plan
- Single write: REQ=1, WR=1, ADDR=15'o12345, DOUT=12'o7070, break_ok=1 -> mem_we one cycle at cycle 2 with addr 12345 / data 7070; dmaGNT at cycle 3; cpu_hold 1..4; IDLE at cycle 5.
- Single read: mem word at 15'o00200 = 12'o4321, RD request -> mem_re at cycle 2; dmaGNT at 3; dmaDIN=4321 at cycle 4 and held.
- Hold wait: break_ok=0 for 10 cycles after REQ -> cpu_hold=1 and no strobes throughout; access occurs 1 cycle after break_ok rises.
- Burst limit with MAX_BURST=4: continuous read requests at addresses 100..105 -> 4 grants 3 cycles apart; cpu_hold=0 for exactly one cycle (GAP); remaining 2 words serviced after break_ok.
- Illegal request: REQ=1 with RD=WR=1 -> no mem_we/mem_re, dmaGNT pulses, dma_err=1 sticky until clear.
- Clear mid-access: assert clear in the ACCESS cycle of a write -> one mem_we, no dmaGNT, all outputs at reset values the next cycle.
